// File: rtl/keycode_pkg.sv
// Shared types for the keycode event generator.
// Event kinds, repeat FSM states and the packed queue entry.
package keycode_pkg;

  localparam int KEYCODE_W = 8;

  typedef logic [1:0] evt_kind_t;

  localparam evt_kind_t EVT_PRESS   = 2'd0;
  localparam evt_kind_t EVT_RELEASE = 2'd1;
  localparam evt_kind_t EVT_REPEAT  = 2'd2;

  typedef struct packed {
    logic [KEYCODE_W-1:0] code;
    evt_kind_t            kind;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_RUN
  } rpt_state_t;

endpackage

// File: rtl/keycode_evt_fifo.sv
// First-word-fall-through event queue.
// A push into a full queue is accepted only when a pop frees a slot.
module keycode_evt_fifo
  import keycode_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [EVT_W-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [EVT_W-1:0] head,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [EVT_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             pop_en;
  logic             push_en;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);
  assign drop    = push & ~push_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_en)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Head reads as zero while empty so outputs are clean after reset.
  assign head_valid = ~empty;
  assign head       = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/keycode_event_gen.sv
// Turns the PIO keycode level into PRESS/RELEASE/REPEAT events.
// Repeats are paced by frame_tick; events drain via valid/ready.
module keycode_event_gen
  import keycode_pkg::*;
#(
  parameter int REPEAT_DELAY = 15,
  parameter int REPEAT_RATE  = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [KEYCODE_W-1:0] keycode,
  input  logic                 frame_tick,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [KEYCODE_W-1:0] evt_code,
  output logic [1:0]           evt_kind,
  output logic [KEYCODE_W-1:0] held_code,
  output logic                 overflow,
  input  logic                 clear_overflow
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RCNT_W = $clog2(RMAX + 1);

  localparam logic [RCNT_W:0] DLY_END =
    (RCNT_W+1)'(REPEAT_DELAY);
  localparam logic [RCNT_W:0] RATE_END =
    (RCNT_W+1)'(REPEAT_RATE);
  localparam rpt_state_t PRESS_ST =
    (REPEAT_DELAY == 0) ? RPT_IDLE : RPT_DELAY;

  logic [KEYCODE_W-1:0] keycode_q;
  logic [KEYCODE_W-1:0] held_nxt;
  rpt_state_t           state;
  rpt_state_t           state_nxt;
  logic [RCNT_W-1:0]    rcnt;
  logic [RCNT_W-1:0]    rcnt_nxt;
  logic [RCNT_W:0]      rcnt_inc;
  logic                 push;
  logic [EVT_W-1:0]     push_evt;
  logic                 drop;
  logic [EVT_W-1:0]     head;

  always_ff @(posedge clk) begin
    if (reset) begin
      keycode_q <= '0;
      held_code <= '0;
      state     <= RPT_IDLE;
      rcnt      <= '0;
    end else begin
      keycode_q <= keycode;
      held_code <= held_nxt;
      state     <= state_nxt;
      rcnt      <= rcnt_nxt;
    end
  end

  // A key change always wins over a repeat due in the same cycle.
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    held_nxt  = held_code;
    push      = 1'b0;
    push_evt  = '0;
    rcnt_inc  = {1'b0, rcnt} + (RCNT_W+1)'(1);
    if (keycode_q != held_code) begin
      push     = 1'b1;
      rcnt_nxt = '0;
      if (held_code != '0) begin
        push_evt  = {held_code, EVT_RELEASE};
        held_nxt  = '0;
        state_nxt = RPT_IDLE;
      end else begin
        push_evt  = {keycode_q, EVT_PRESS};
        held_nxt  = keycode_q;
        state_nxt = PRESS_ST;
      end
    end else if (frame_tick) begin
      case (state)
        RPT_DELAY: begin
          if (rcnt_inc == DLY_END) begin
            push      = 1'b1;
            push_evt  = {held_code, EVT_REPEAT};
            state_nxt = RPT_RUN;
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt = rcnt_inc[RCNT_W-1:0];
          end
        end
        RPT_RUN: begin
          if (rcnt_inc == RATE_END) begin
            push     = 1'b1;
            push_evt = {held_code, EVT_REPEAT};
            rcnt_nxt = '0;
          end else begin
            rcnt_nxt = rcnt_inc[RCNT_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)               overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

  keycode_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_evt),
    .pop        (evt_ready),
    .head_valid (evt_valid),
    .head       (head),
    .drop       (drop)
  );

  assign evt_code = head[EVT_W-1:2];
  assign evt_kind = head[1:0];

endmodule

// File: tb/tb_keycode_event_gen.sv
// Bench for keycode_event_gen: directed scenarios plus
// randomized traffic against a queue-based behavioural model.
module tb_keycode_event_gen;
  import keycode_pkg::*;

  localparam int D     = 15;
  localparam int R     = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] keycode;
  logic       frame_tick;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic [1:0] evt_kind;
  logic [7:0] held_code;
  logic       overflow;
  logic       clear_overflow;

  int checks = 0;
  int errors = 0;

  logic [9:0] mq[$];
  logic [7:0] m_kq;
  logic [7:0] m_held;
  logic       m_ovf;
  int         m_ticks;
  int         m_reps;

  logic [9:0] obs_ev[$];
  int         obs_t[$];

  keycode_event_gen #(
    .REPEAT_DELAY (D),
    .REPEAT_RATE  (R),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .keycode        (keycode),
    .frame_tick     (frame_tick),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_code       (evt_code),
    .evt_kind       (evt_kind),
    .held_code      (held_code),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  // Model: events derived from key history; repeat n fires at
  // tick D + n*R counted from the press.
  task automatic cycle();
    logic [9:0] ev;
    bit         have;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_kq = 0; m_held = 0; m_ovf = 0;
      m_ticks = 0; m_reps = 0;
    end else begin
      have = 0;
      ev   = '0;
      if (m_kq != m_held) begin
        have = 1;
        if (m_held != 0) begin
          ev = {m_held, EVT_RELEASE};
          m_held = 0;
        end else begin
          ev = {m_kq, EVT_PRESS};
          m_held = m_kq;
          m_ticks = 0; m_reps = 0;
        end
      end else if (m_held != 0 && D > 0 && frame_tick) begin
        m_ticks++;
        if (m_ticks == D + m_reps * R) begin
          ev = {m_held, EVT_REPEAT};
          m_reps++;
          have = 1;
        end
      end
      if (evt_ready && mq.size() > 0) void'(mq.pop_front());
      if (have && mq.size() < DEPTH) mq.push_back(ev);
      if (have && mq.size() >= DEPTH && mq[$] != ev) m_ovf = 1;
      else if (clear_overflow) m_ovf = 0;
      m_kq = keycode;
    end
    #1;
  endtask

  task automatic record(input int t);
    if (evt_valid) begin
      obs_ev.push_back({evt_code, evt_kind});
      obs_t.push_back(t);
    end
  endtask

  task automatic test_reset();
    reset = 1; keycode = 8'h55; frame_tick = 0;
    evt_ready = 0; clear_overflow = 0;
    cycle(); cycle();
    checks++;
    if ({evt_valid, evt_code, evt_kind, held_code, overflow}
        !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: got %b %h %0d %h %b want 0",
               evt_valid, evt_code, evt_kind, held_code, overflow);
    end
    keycode = 0; reset = 0;
    cycle(); cycle();
    checks++;
    if (evt_valid !== 1'b0 || held_code !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle: valid %b held %h want 0 00",
               evt_valid, held_code);
    end
  endtask

  task automatic test_press_release();
    evt_ready = 1; keycode = 8'h04;
    cycle();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL press_latency1: valid %b want 0", evt_valid);
    end
    cycle();
    checks++;
    if ({evt_valid, evt_code, evt_kind, held_code} !==
        {1'b1, 8'h04, EVT_PRESS, 8'h04}) begin
      errors++;
      $display("FAIL press_evt: got %b %h %0d %h want 1 04 0 04",
               evt_valid, evt_code, evt_kind, held_code);
    end
    repeat (3) cycle();
    checks++;
    if (evt_valid !== 1'b0 || held_code !== 8'h04) begin
      errors++;
      $display("FAIL press_hold: valid %b held %h want 0 04",
               evt_valid, held_code);
    end
    keycode = 0;
    cycle(); cycle();
    checks++;
    if ({evt_valid, evt_code, evt_kind, held_code} !==
        {1'b1, 8'h04, EVT_RELEASE, 8'h00}) begin
      errors++;
      $display("FAIL release_evt: got %b %h %0d %h want 1 04 1 00",
               evt_valid, evt_code, evt_kind, held_code);
    end
    repeat (2) cycle();
  endtask

  task automatic test_key_to_key();
    evt_ready = 1; keycode = 8'h04;
    repeat (4) cycle();
    obs_ev.delete(); obs_t.delete();
    keycode = 8'h07;
    for (int i = 0; i < 6; i++) begin
      cycle();
      record(i);
    end
    checks++;
    if (obs_ev.size() != 2) begin
      errors++;
      $display("FAIL k2k_count: got %0d events want 2",
               obs_ev.size());
    end else begin
      checks++;
      if (obs_ev[0] !== {8'h04, EVT_RELEASE} ||
          obs_ev[1] !== {8'h07, EVT_PRESS} ||
          obs_t[1] != obs_t[0] + 1) begin
        errors++;
        $display("FAIL k2k_seq: got %h@%0d %h@%0d want 011 01c",
                 obs_ev[0], obs_t[0], obs_ev[1], obs_t[1]);
      end
    end
    keycode = 0;
    repeat (5) cycle();
  endtask

  task automatic test_auto_repeat();
    logic [9:0] want_ev [5];
    int         want_t  [5];
    want_ev = '{{8'h1A, EVT_PRESS}, {8'h1A, EVT_REPEAT},
                {8'h1A, EVT_REPEAT}, {8'h1A, EVT_REPEAT},
                {8'h1A, EVT_RELEASE}};
    want_t  = '{0, 15, 19, 23, 23};
    obs_ev.delete(); obs_t.delete();
    evt_ready = 1; keycode = 8'h1A;
    repeat (4) begin cycle(); record(0); end
    for (int t = 1; t <= 23; t++) begin
      frame_tick = 1; cycle(); frame_tick = 0; record(t);
      cycle(); record(t);
      cycle(); record(t);
    end
    keycode = 0;
    repeat (4) begin cycle(); record(23); end
    for (int t = 0; t < 10; t++) begin
      frame_tick = 1; cycle(); frame_tick = 0; record(23);
      cycle(); record(23);
    end
    checks++;
    if (obs_ev.size() != 5) begin
      errors++;
      $display("FAIL repeat_count: got %0d events want 5",
               obs_ev.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (obs_ev[i] !== want_ev[i] || obs_t[i] != want_t[i]) begin
          errors++;
          $display("FAIL repeat_evt%0d: got %h@tick%0d want %h@%0d",
                   i, obs_ev[i], obs_t[i], want_ev[i], want_t[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [9:0] want;
    evt_ready = 0;
    for (int i = 0; i < 5; i++) begin
      keycode = 8'h10 + 8'(i); repeat (3) cycle();
      keycode = 0;             repeat (3) cycle();
    end
    checks++;
    if (overflow !== 1'b1 || held_code !== 8'h00) begin
      errors++;
      $display("FAIL ovf_set: ovf %b held %h want 1 00",
               overflow, held_code);
    end
    evt_ready = 1;
    for (int k = 0; k < 8; k++) begin
      want = {8'h10 + 8'(k / 2),
              (k % 2) ? EVT_RELEASE : EVT_PRESS};
      checks++;
      if (evt_valid !== 1'b1 || {evt_code, evt_kind} !== want) begin
        errors++;
        $display("FAIL ovf_drain%0d: got %b %h want 1 %h",
                 k, evt_valid, {evt_code, evt_kind}, want);
      end
      cycle();
    end
    checks++;
    if (evt_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after_drain: valid %b ovf %b want 0 1",
               evt_valid, overflow);
    end
    clear_overflow = 1; cycle(); clear_overflow = 0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b want 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    int         n;
    logic [9:0] last;
    evt_ready = 0;
    for (int i = 0; i < 4; i++) begin
      keycode = 8'h20 + 8'(i); repeat (3) cycle();
      keycode = 0;             repeat (3) cycle();
    end
    keycode = 8'h33;
    cycle();
    evt_ready = 1;
    cycle();
    evt_ready = 0;
    checks++;
    if (overflow !== 1'b0 ||
        {evt_code, evt_kind} !== {8'h20, EVT_RELEASE}) begin
      errors++;
      $display("FAIL full_pp: ovf %b head %h want 0 081",
               overflow, {evt_code, evt_kind});
    end
    n = 0; last = '0;
    evt_ready = 1;
    for (int i = 0; i < 12; i++) begin
      if (evt_valid) begin n++; last = {evt_code, evt_kind}; end
      cycle();
    end
    checks++;
    if (n != 8 || last !== {8'h33, EVT_PRESS}) begin
      errors++;
      $display("FAIL full_pp_count: got %0d last %h want 8 0cc",
               n, last);
    end
    keycode = 0;
    repeat (4) cycle();
  endtask

  task automatic test_reset_mid_hold();
    evt_ready = 0;
    keycode = 8'h05; repeat (3) cycle();
    keycode = 0;     repeat (3) cycle();
    keycode = 8'h2C; repeat (3) cycle();
    reset = 1; cycle(); reset = 0;
    checks++;
    if (evt_valid !== 1'b0 || held_code !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid: valid %b held %h want 0 00",
               evt_valid, held_code);
    end
    cycle();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_lat: valid %b want 0", evt_valid);
    end
    cycle();
    checks++;
    if ({evt_valid, evt_code, evt_kind, held_code} !==
        {1'b1, 8'h2C, EVT_PRESS, 8'h2C}) begin
      errors++;
      $display("FAIL rst_mid_press: got %b %h %0d %h want 1 2c 0 2c",
               evt_valid, evt_code, evt_kind, held_code);
    end
    evt_ready = 1; keycode = 0;
    repeat (5) cycle();
  endtask

  task automatic test_random();
    logic [9:0] head;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0)
        keycode = ($urandom_range(0, 2) == 0) ?
                  8'h00 : 8'($urandom_range(1, 255));
      frame_tick     = ($urandom_range(0, 2) == 0);
      evt_ready      = ($urandom_range(0, 1) == 0);
      clear_overflow = ($urandom_range(0, 31) == 0);
      reset          = ($urandom_range(0, 499) == 0);
      cycle();
      head = (mq.size() > 0) ? mq[0] : 10'h0;
      checks++;
      if (evt_valid !== (mq.size() > 0) ||
          {evt_code, evt_kind} !== head ||
          held_code !== m_held || overflow !== m_ovf) begin
        errors++;
        $display("FAIL rand@%0d: got %b %h %h %b want %b %h %h %b",
                 c, evt_valid, {evt_code, evt_kind}, held_code,
                 overflow, mq.size() > 0, head, m_held, m_ovf);
      end
    end
    reset = 0; frame_tick = 0; clear_overflow = 0;
  endtask

  initial begin
    reset = 1; keycode = 0; frame_tick = 0;
    evt_ready = 0; clear_overflow = 0;
    test_reset();
    test_press_release();
    test_key_to_key();
    test_auto_repeat();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keycode_event_gen.md
# keycode_event_gen

- Converts the 8-bit keycode level from the keycode PIO `out_port` into a queue of discrete key events: PRESS, RELEASE and auto-REPEAT.
- Repeats are paced by a frame tick.
- The game/control logic pops events through a valid/ready handshake.
- Sits directly downstream of the keycode PIO in the final-project SoC fabric.

## Interface
Parameters:
- `REPEAT_DELAY`, 15: frame ticks from PRESS to first REPEAT; 0 disables auto-repeat.
- `REPEAT_RATE`, 4: frame ticks between subsequent REPEATs; must be ≥1.
- `FIFO_DEPTH`, 8: event queue entries; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `keycode`  in  8  keycode level from PIO; 0 = no key.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `evt_valid`  out  1  queue head valid.
- `evt_ready`  in  1  consumer accepts head when `evt_valid & evt_ready`.
- `evt_code`  out  8  keycode of head event.
- `evt_kind`  out  2  0 PRESS, 1 RELEASE, 2 REPEAT; 3 never produced.
- `held_code`  out  8  currently tracked key; 0 = none.
- `overflow`  out  1  sticky: an event was dropped.
- `clear_overflow`  in  1  clears `overflow`.

## Operation
- **Input register.** `keycode` is registered into `keycode_q` every cycle. All decisions use `keycode_q`.
- **Change tracking, one event max per cycle.** If `keycode_q != held_code`:
  - if `held_code != 0`: push RELEASE(`held_code`), `held_code <= 0`;
  - else: push PRESS(`keycode_q`), `held_code <= keycode_q`.
  - Direct key-to-key change A→B therefore yields RELEASE(A), then PRESS(B) on the next cycle.
  - If `keycode_q` changes again before PRESS, the PRESS uses the newest value.
- **Repeat FSM.** States IDLE, DELAY, RPT; counter `rcnt` of width clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
  - Any PRESS → DELAY, `rcnt <= 0`.
  - Any RELEASE → IDLE.
  - DELAY: each `frame_tick` increments `rcnt`. The tick that makes `rcnt == REPEAT_DELAY` pushes REPEAT(`held_code`) and moves to RPT with `rcnt <= 0`.
  - RPT: the same rule with REPEAT_RATE; stays in RPT.
  - REPEAT_DELAY = 0: FSM never leaves IDLE.
- **Priority.** A change event beats a repeat in the same cycle; the repeat is discarded and the FSM follows the change rule.
- **FIFO.** First-word-fall-through; the head drives `evt_code`/`evt_kind`. Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Push when full with no pop: event dropped, `overflow <= 1`. `held_code` and the FSM still update as if pushed, so tracking stays consistent.
  - Push when full with a pop in the same cycle: accepted, count unchanged.
  - Pop when empty: ignored.
- **Overflow flag.** `clear_overflow` clears `overflow`. If a drop occurs in the same cycle, the set wins.
- **Reset.** `reset` clears everything: `evt_valid=0`, `evt_code=0`, `evt_kind=0`, `held_code=0`, `overflow=0`, `keycode_q=0`, FSM IDLE, `rcnt=0`, queue empty.
  - Reset mid-operation discards queued events.
  - A non-zero `keycode` after reset produces a fresh PRESS.

## Timing
- `keycode` stable before edge E0 → `keycode_q` updates at E0 → event written at E1 → `evt_valid=1` after E1 when the queue was empty. Latency is 2 clocks.
- A→B change: RELEASE written at E1, PRESS at E2.
- Repeat: the REPEAT is written at the edge that samples the qualifying `frame_tick`; visible one cycle later when the queue was empty.
- Pop takes effect at the handshake edge; the next entry is presented in the following cycle.
- Outputs hold stable while `evt_valid & ~evt_ready`.
- `held_code` updates at the same edge the event is written.

## Structure
- **Shared package `keycode_pkg`:** `EVT_PRESS`/`EVT_RELEASE`/`EVT_REPEAT` constants, the 2-bit kind type, FSM state encoding, `KEYCODE_W=8`.
- **Sub-module `keycode_evt_fifo`:** 10-bit wide (code + kind), FWFT, with full/empty and the same-cycle push-pop rule above.
- The top level contains the input register, change tracker, repeat FSM and overflow flag.

## Test plan
- **Single press/release.** Reset, `evt_ready=1`, `keycode` 0→0x04, hold, then →0.
  - Expect PRESS(0x04) with `evt_valid` 2 cycles after the change, then RELEASE(0x04).
  - `held_code` goes 0x04, then 0.
- **Key-to-key change.** Hold 0x04, then `keycode` → 0x07.
  - Expect RELEASE(0x04) and PRESS(0x07) on consecutive cycles; no REPEAT.
- **Auto-repeat.** Defaults, hold 0x1A, pulse `frame_tick` 23 times.
  - Expect PRESS, then REPEAT at tick 15, tick 19 and tick 23.
  - After release: no further REPEAT.
- **Overflow.** `evt_ready=0`, generate 10 events with FIFO_DEPTH 8.
  - Expect 8 stored, `overflow=1`.
  - Drain: the 8 events come out in order.
  - `clear_overflow` → `overflow=0`.
- **Full-boundary push/pop.** Queue full, push and pop in the same cycle.
  - Expect the push accepted, count stays 8, `overflow` unchanged.
- **Reset mid-hold.** Hold 0x2C with 3 events queued, assert `reset` for 1 cycle.
  - Queue empty, `held_code=0`.
  - With 0x2C still present: a new PRESS(0x2C) appears 2 cycles after reset deasserts.
